// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router datapath.
// Holds the byte and FIFO geometry, the layout of the header byte, the
// {lfd, byte} FIFO word type and the header-to-byte-count helper used on
// the read side of each output FIFO.
package router_pkg;

  localparam int ROUTER_DATA_W     = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;

  // Header byte layout: [7:2] payload length, [1:0] destination address.
  localparam int LEN_MSB    = 7;
  localparam int LEN_LSB    = 2;
  localparam int ADDR_MSB   = 1;
  localparam int ADDR_LSB   = 0;
  localparam int LEN_W      = LEN_MSB - LEN_LSB + 1;
  localparam int BYTE_CNT_W = 7;

  // One FIFO entry: header tag plus the stored byte.
  typedef struct packed {
    logic                     lfd;
    logic [ROUTER_DATA_W-1:0] data;
  } fifo_word_t;

  // Bytes still to deliver after the header: payload length plus parity.
  function automatic logic [BYTE_CNT_W-1:0] hdr_to_count(input logic [LEN_W-1:0] len);
    return {1'b0, len} + 7'd1;
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array for the router output FIFO.
// Ports:
//   clock    in   rising-edge clock
//   wr_en    in   write strobe (already qualified against full)
//   wr_addr  in   write address
//   wr_data  in   word to store
//   rd_addr  in   read address
//   rd_data  out  word at rd_addr (combinational read)
module router_fifo_mem #(
  parameter int W      = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; the pointers alone define which entries
  // are valid, so clearing storage would only cost flops and reset fan-out.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_fifo_buf.sv
// Per-destination output FIFO of the 1x3 router.
// Stores {lfd_state, data_in} words written by the register stage and tracks
// the byte count of the packet being read, so the output stage can tell when
// the packet in flight is complete. soft_reset (synchronizer timeout) flushes
// the FIFO exactly like reset.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset, clears all state
//   soft_reset  in   synchronous active-high flush, same effect as reset
//   write_enb   in   write request from the synchronizer
//   read_enb    in   read request from the destination
//   lfd_state   in   word being written is a header byte
//   data_in     in   byte from the register-stage dout
//   data_out    out  registered read data
//   full        out  DEPTH words stored
//   empty       out  no words stored
//   pkt_active  out  read-side packet in progress (byte count != 0)
module router_fifo_buf
  import router_pkg::*;
#(
  parameter int DATA_W = ROUTER_DATA_W,
  parameter int DEPTH  = ROUTER_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              pkt_active
);

  localparam logic [ADDR_W:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0]     wr_ptr;
  logic [ADDR_W:0]     rd_ptr;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [DATA_W:0]     wr_word;
  logic [DATA_W:0]     rd_word;
  logic                wr_accept;
  logic                rd_accept;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // Flags come from the registered pointers, so a write while full or a read
  // while empty is simply not accepted; simultaneous access degrades to the
  // single legal operation.
  assign wr_accept = write_enb && !full;
  assign rd_accept = read_enb && !empty;

  assign pkt_active = (byte_cnt != '0);
  assign wr_word    = {lfd_state, data_in};

  router_fifo_mem #(
    .W      (DATA_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_word),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values (flags, byte_cnt) regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      byte_cnt <= '0;
      data_out <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (rd_accept) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= rd_word[DATA_W-1:0];
        if (rd_word[DATA_W]) begin
          // A header always reloads, even over a truncated previous packet.
          byte_cnt <= hdr_to_count(rd_word[LEN_MSB:LEN_LSB]);
        end else if (byte_cnt != '0) begin
          byte_cnt <= byte_cnt - 7'd1;
        end
        // Stray non-header byte with count 0: delivered, count stays 0.
      end else if (byte_cnt == '0) begin
        // Idle between packets: drive a clean zero on the output bus.
        data_out <= '0;
      end
    end
  end

endmodule
